// File: rtl/uart_rx.sv
// 8N1-style UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle
// data and framing-error strobes.
module uart_rx #(
    parameter int BAUD_DIV       = 8,
    parameter int BAUD_DIV_WIDTH = 8,
    parameter int W              = 8
) (
    input  logic         c,
    input  logic         rst_n,
    input  logic         rx,
    output logic [W-1:0] out,
    output logic         out_en,
    output logic         frame_err,
    output logic         busy
);

    localparam int IDX_W = $clog2(W) + 1;
    localparam logic [BAUD_DIV_WIDTH-1:0] CNT_LAST = BAUD_DIV_WIDTH'(BAUD_DIV - 1);
    localparam logic [BAUD_DIV_WIDTH-1:0] CNT_HALF = BAUD_DIV_WIDTH'(BAUD_DIV / 2 - 1);
    localparam logic [IDX_W-1:0]          IDX_LAST = IDX_W'(W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT
    } state_t;

    state_t                    state, state_nxt;
    logic                      rx_meta, rx_s;
    logic [BAUD_DIV_WIDTH-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0]          bit_idx, bit_idx_nxt;
    logic [W-1:0]              shift_reg, shift_nxt;
    logic [W-1:0]              out_nxt;
    logic                      armed, armed_nxt;
    logic                      out_en_nxt, frame_err_nxt;

    // rx is asynchronous to c; nothing downstream may look at it before rx_s
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            armed     <= 1'b0;
            out       <= '0;
            out_en    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_nxt;
            armed     <= armed_nxt;
            out       <= out_nxt;
            out_en    <= out_en_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // Leaving ST_STOP at the stop-bit centre leaves half a bit to re-arm for a back-to-back start
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift_reg;
        armed_nxt     = armed;
        out_nxt       = out;
        out_en_nxt    = 1'b0;
        frame_err_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx_s) begin
                    armed_nxt = 1'b1;
                end else if (armed) begin
                    state_nxt = ST_START;
                    cnt_nxt   = '0;
                    armed_nxt = 1'b0;
                end
            end
            ST_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = ST_DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s, shift_reg[W-1:1]};
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        out_nxt    = shift_reg;
                        out_en_nxt = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_WAIT;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_WAIT: begin
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                    armed_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                armed_nxt = 1'b0;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule
